score_round_ctrl: RTL and testbench
===================================

Name: score_round_ctrl

Overview:
- Game-flow controller that sits directly upstream of the seven-segment display path and beside the player-input gating.
- Consumes the collision flag and per-player crash flags from the trace renderer and tracks the score and round number.
- Sequences rounds (play, hold, restart, game over) and emits a round-restart pulse plus a freeze level that zeroes the player direction inputs.
- Provides two-digit BCD score and round values that feed the BCD-to-seven-segment decoders directly.

Parameters:
HOLD_CYCLES, 80_000_000, clocks spent frozen between rounds (2 s at 40 MHz); legal range >= 1
HOLD_W, 27, width of the hold down-counter; must satisfy 2**HOLD_W > HOLD_CYCLES
WIN_SCORE, 5, score (binary, 1..99) that ends the game

Ports:
clock  input  1  pixel clock, 40 MHz; all logic is on its rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  synchronized button level; only its rising edge is used
collided  input  1  level from the trace renderer; high while a crash is present
p1_crashed  input  1  player 1 hit something; qualified by the collided rising edge
p2_crashed  input  1  player 2 hit something; qualified by the collided rising edge
freeze  output  1  high means direction inputs are forced to zero
round_reset  output  1  one-cycle pulse that clears traces and respawns players
game_over  output  1  high in the OVER state
winner  output  2  00 none, 01 player 1, 10 player 2; valid while game_over is high
p1_score_bcd  output  8  {tens, ones} BCD
p2_score_bcd  output  8  {tens, ones} BCD
round_bcd  output  8  {tens, ones} BCD, current round number
state_o  output  2  00 IDLE, 01 PLAY, 10 HOLD, 11 OVER

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, freeze=1, round_reset=0, game_over=0, winner=00, all BCD outputs 8'h00, hold counter 0, edge registers 0.
- Edge detection: start_rise = start & ~start_q; col_rise = collided & ~collided_q. Both _q registers update every cycle in every state.
- IDLE:
  - On start_rise: go to PLAY, round_bcd=01, freeze=0, round_reset=1 for exactly one cycle.
- PLAY:
  - On col_rise, score the round and update scores in the same edge:
    - only p1_crashed set: p2 scores +1
    - only p2_crashed set: p1 scores +1
    - both set, or neither set: draw, no score change
  - If the new score of the scoring player equals WIN_SCORE: go to OVER, game_over=1, winner set, freeze=1.
  - Otherwise: go to HOLD, load counter with HOLD_CYCLES-1, freeze=1.
  - start is ignored in PLAY. If start_rise and col_rise occur together, the collision is processed.
- HOLD:
  - Counter decrements each cycle. The block stays in HOLD for exactly HOLD_CYCLES clocks.
  - When counter==0: go to PLAY, round_bcd+1, freeze=0, round_reset pulse.
  - start and collided are ignored in HOLD.
  - If collided is still high on re-entering PLAY, it is not scored again; only a fresh rising edge scores.
- OVER:
  - Holds scores and winner.
  - On start_rise: scores go to 00, round_bcd=01, game_over=0, winner=00, go to PLAY, freeze=0, round_reset pulse.
- Latency: score, state, freeze and round_reset all change on the clock edge that samples col_rise / start_rise / counter==0, and are visible one cycle after the triggering input rises.
- BCD arithmetic:
  - Increment the ones digit. If ones==9: ones=0 and tens+1.
  - If tens==9 and ones==9: result is 00 (wrap).
  - Digits never take values A-F.
- Win comparison: compare against the BCD equivalent of WIN_SCORE, computed at elaboration as {WIN_SCORE/10, WIN_SCORE%10}.
- round_reset is never high for two consecutive cycles.
- freeze is high in IDLE, HOLD and OVER, and low only in PLAY.
- An asserted reset at any point, including mid-HOLD, returns the block to IDLE with reset values immediately (asynchronously). After release, the first start_rise is required to play.

Test Plan:
(Bench uses HOLD_CYCLES=4, WIN_SCORE=3.)
1. Reset then start pulse -> next cycle state_o=01, round_bcd=8'h01, freeze=0, round_reset high for 1 cycle only.
2. In PLAY, collided rises with p1_crashed=1, p2_crashed=0 -> p2_score_bcd=8'h01, state_o=10, freeze=1. After exactly 4 cycles: state_o=01, round_bcd=8'h02, round_reset pulse.
3. collided rises with both crash bits set -> scores unchanged, HOLD entered. collided held high across the return to PLAY -> no additional score.
4. Player 1 wins 3 rounds -> p1_score_bcd=8'h03, state_o=11, game_over=1, winner=01, no round_reset. Start -> scores 00, round_bcd=01, game_over=0, one round_reset pulse.
5. Separate run with WIN_SCORE=99: force 10 rounds and observe round_bcd step 09 -> 10. Force round 99 -> next round_bcd=8'h00.
6. Assert reset two cycles into HOLD -> all outputs return to reset values immediately. Start pressed and collided toggled together in PLAY -> collision is scored, start is ignored.

Source files
------------

// File: rtl/score_round_ctrl.sv
// score_round_ctrl
// ----------------
// Game-flow controller for a two-player trace game. It watches the collision
// level and the per-player crash flags from the trace renderer, keeps both
// scores and the round number as two-digit BCD, and sequences rounds through
// IDLE -> PLAY -> HOLD -> PLAY ... -> OVER.
//
// Ports
//   clock         pixel clock (40 MHz), all logic on its rising edge
//   reset         asynchronous, active-high; clears all state
//   start         synchronized button level; only its rising edge matters
//   collided      high while a crash is present on screen
//   p1_crashed    player 1 hit something (qualified by collided rising edge)
//   p2_crashed    player 2 hit something (qualified by collided rising edge)
//   freeze        high forces the player direction inputs to zero
//   round_reset   one-cycle pulse: clear traces and respawn players
//   game_over     high in OVER
//   winner        00 none, 01 player 1, 10 player 2 (valid with game_over)
//   p1_score_bcd  {tens, ones}
//   p2_score_bcd  {tens, ones}
//   round_bcd     {tens, ones}, current round number
//   state_o       00 IDLE, 01 PLAY, 10 HOLD, 11 OVER (registered state)
//
// There is no valid/ready handshake on this block: inputs are levels whose
// rising edges are detected internally, and every output is a register.

module score_round_ctrl #(
  parameter int HOLD_CYCLES = 80_000_000,
  parameter int HOLD_W      = 27,
  parameter int WIN_SCORE   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       collided,
  input  logic       p1_crashed,
  input  logic       p2_crashed,
  output logic       freeze,
  output logic       round_reset,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] p1_score_bcd,
  output logic [7:0] p2_score_bcd,
  output logic [7:0] round_bcd,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HOLD = 2'b10,
    OVER = 2'b11
  } state_t;

  // Winning score converted to BCD once, so the compare runs on BCD directly.
  localparam logic [3:0] WIN_TENS = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WIN_ONES = 4'(WIN_SCORE % 10);
  localparam logic [7:0] WIN_BCD  = {WIN_TENS, WIN_ONES};

  // Counter runs HOLD_CYCLES-1 down to 0, giving exactly HOLD_CYCLES clocks.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  logic              start_q;
  logic              collided_q;
  logic [HOLD_W-1:0] hold_cnt;

  logic       start_rise;
  logic       col_rise;
  logic       p1_point;
  logic       p2_point;
  logic [7:0] p1_next;
  logic [7:0] p2_next;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      if (tens == 4'd9) tens = 4'd0;
      else              tens = tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  assign start_rise = start & ~start_q;
  assign col_rise   = collided & ~collided_q;

  // A point goes to the player who did NOT crash; a double crash or a
  // collision with no crash flag is a draw.
  assign p1_point = p2_crashed & ~p1_crashed;
  assign p2_point = p1_crashed & ~p2_crashed;
  assign p1_next  = bcd_inc(p1_score_bcd);
  assign p2_next  = bcd_inc(p2_score_bcd);

  assign state_o = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      collided_q   <= 1'b0;
      hold_cnt     <= '0;
      freeze       <= 1'b1;
      round_reset  <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      p1_score_bcd <= 8'h00;
      p2_score_bcd <= 8'h00;
      round_bcd    <= 8'h00;
    end else begin
      start_q     <= start;
      collided_q  <= collided;
      round_reset <= 1'b0;

      case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= PLAY;
            round_bcd   <= 8'h01;
            freeze      <= 1'b0;
            round_reset <= 1'b1;
          end
        end

        PLAY: begin
          // start is deliberately ignored here, even on the same edge.
          if (col_rise) begin
            if (p1_point) p1_score_bcd <= p1_next;
            if (p2_point) p2_score_bcd <= p2_next;
            freeze <= 1'b1;
            if (p1_point && (p1_next == WIN_BCD)) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 2'b01;
            end else if (p2_point && (p2_next == WIN_BCD)) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 2'b10;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end

        HOLD: begin
          // collided_q keeps tracking here, so a collision level still high
          // on return to PLAY produces no fresh rising edge.
          if (hold_cnt == '0) begin
            state       <= PLAY;
            round_bcd   <= bcd_inc(round_bcd);
            freeze      <= 1'b0;
            round_reset <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        OVER: begin
          if (start_rise) begin
            state        <= PLAY;
            p1_score_bcd <= 8'h00;
            p2_score_bcd <= 8'h00;
            round_bcd    <= 8'h01;
            game_over    <= 1'b0;
            winner       <= 2'b00;
            freeze       <= 1'b0;
            round_reset  <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_round_ctrl.sv
// Bench for score_round_ctrl. Two instances share one input stream:
// index 0 is built with WIN_SCORE=3, index 1 with WIN_SCORE=99 (used for the
// long round-counter run). Both use HOLD_CYCLES=4. A per-instance reference
// model keeps scores and round number as plain integers and converts to BCD
// only when comparing.

module tb_score_round_ctrl;

  localparam int HOLD = 4;

  logic clock;
  logic reset;
  logic start;
  logic collided;
  logic p1_crashed;
  logic p2_crashed;

  logic       o_freeze [2];
  logic       o_rr     [2];
  logic       o_go     [2];
  logic [1:0] o_win    [2];
  logic [7:0] o_p1     [2];
  logic [7:0] o_p2     [2];
  logic [7:0] o_rnd    [2];
  logic [1:0] o_st     [2];

  score_round_ctrl #(.HOLD_CYCLES(HOLD), .HOLD_W(3), .WIN_SCORE(3)) dut_a (
    .clock(clock), .reset(reset), .start(start), .collided(collided),
    .p1_crashed(p1_crashed), .p2_crashed(p2_crashed),
    .freeze(o_freeze[0]), .round_reset(o_rr[0]), .game_over(o_go[0]),
    .winner(o_win[0]), .p1_score_bcd(o_p1[0]), .p2_score_bcd(o_p2[0]),
    .round_bcd(o_rnd[0]), .state_o(o_st[0])
  );

  score_round_ctrl #(.HOLD_CYCLES(HOLD), .HOLD_W(3), .WIN_SCORE(99)) dut_b (
    .clock(clock), .reset(reset), .start(start), .collided(collided),
    .p1_crashed(p1_crashed), .p2_crashed(p2_crashed),
    .freeze(o_freeze[1]), .round_reset(o_rr[1]), .game_over(o_go[1]),
    .winner(o_win[1]), .p1_score_bcd(o_p1[1]), .p2_score_bcd(o_p2[1]),
    .round_bcd(o_rnd[1]), .state_o(o_st[1])
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: phase 0 idle, 1 play, 2 hold, 3 over
  int win_at [2] = '{3, 99};
  int m_ph   [2];
  int m_p1   [2];
  int m_p2   [2];
  int m_rnd  [2];
  int m_left [2];
  int m_win  [2];
  bit m_rr   [2];
  bit m_sq   [2];
  bit m_cq   [2];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_p1[k] = 0; m_p2[k] = 0; m_rnd[k] = 0;
      m_left[k] = 0; m_win[k] = 0; m_rr[k] = 0; m_sq[k] = 0; m_cq[k] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit c, input bit x1, input bit x2);
    bit sr;
    bit cr;
    int who;
    for (int k = 0; k < 2; k++) begin
      sr = s && !m_sq[k];
      cr = c && !m_cq[k];
      m_rr[k] = 0;
      case (m_ph[k])
        0: if (sr) begin m_ph[k] = 1; m_rnd[k] = 1; m_rr[k] = 1; end
        1: if (cr) begin
          who = 0;
          if (x1 && !x2) begin m_p2[k]++; who = 2; end
          else if (x2 && !x1) begin m_p1[k]++; who = 1; end
          if (who == 1 && m_p1[k] == win_at[k]) begin m_ph[k] = 3; m_win[k] = 1; end
          else if (who == 2 && m_p2[k] == win_at[k]) begin m_ph[k] = 3; m_win[k] = 2; end
          else begin m_ph[k] = 2; m_left[k] = HOLD; end
        end
        2: begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_ph[k] = 1; m_rnd[k] = (m_rnd[k] + 1) % 100; m_rr[k] = 1;
          end
        end
        default: if (sr) begin
          m_ph[k] = 1; m_p1[k] = 0; m_p2[k] = 0; m_rnd[k] = 1;
          m_win[k] = 0; m_rr[k] = 1;
        end
      endcase
      m_sq[k] = s;
      m_cq[k] = c;
    end
  endtask

  // scoreboard: every output of both instances against the model
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.state_o", k), 8'(o_st[k]), 8'(m_ph[k]));
      chk($sformatf("u%0d.freeze", k), 8'(o_freeze[k]), 8'(m_ph[k] != 1));
      chk($sformatf("u%0d.round_reset", k), 8'(o_rr[k]), 8'(m_rr[k]));
      chk($sformatf("u%0d.game_over", k), 8'(o_go[k]), 8'(m_ph[k] == 3));
      chk($sformatf("u%0d.winner", k), 8'(o_win[k]), 8'(m_win[k]));
      chk($sformatf("u%0d.p1_score", k), o_p1[k], to_bcd(m_p1[k]));
      chk($sformatf("u%0d.p2_score", k), o_p2[k], to_bcd(m_p2[k]));
      chk($sformatf("u%0d.round", k), o_rnd[k], to_bcd(m_rnd[k]));
    end
  endtask

  // driver tasks
  task automatic step(input bit s, input bit c, input bit x1, input bit x2);
    @(negedge clock);
    start = s; collided = c; p1_crashed = x1; p2_crashed = x2;
    @(posedge clock);
    model_step(s, c, x1, x2);
    #1;
    check_all();
  endtask

  // One collision followed by a full hold with collided released.
  task automatic play_round(input bit x1, input bit x2);
    step(1'b0, 1'b1, x1, x2);
    repeat (HOLD) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset raised between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clock);
    start = 0; collided = 0; p1_crashed = 0; p2_crashed = 0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; collided = 0; p1_crashed = 0; p2_crashed = 0;
    model_reset();

    // 1: reset, then start
    do_reset();
    chk("reset.freeze", 8'(o_freeze[0]), 8'h01);
    chk("reset.round", o_rnd[0], 8'h00);
    step(1, 0, 0, 0);
    chk("start.state", 8'(o_st[0]), 8'h01);
    chk("start.round", o_rnd[0], 8'h01);
    chk("start.freeze", 8'(o_freeze[0]), 8'h00);
    chk("start.rr_on", 8'(o_rr[0]), 8'h01);
    step(1, 0, 0, 0);
    chk("start.rr_off", 8'(o_rr[0]), 8'h00);

    // 2: p1 crashes -> p2 scores, hold lasts exactly HOLD cycles
    step(0, 1, 1, 0);
    chk("crash.p2", o_p2[0], 8'h01);
    chk("crash.state", 8'(o_st[0]), 8'h02);
    chk("crash.freeze", 8'(o_freeze[0]), 8'h01);
    repeat (HOLD - 1) begin
      step(0, 0, 0, 0);
      chk("hold.state", 8'(o_st[0]), 8'h02);
    end
    step(0, 0, 0, 0);
    chk("hold_end.state", 8'(o_st[0]), 8'h01);
    chk("hold_end.round", o_rnd[0], 8'h02);
    chk("hold_end.rr", 8'(o_rr[0]), 8'h01);

    // 3: draw, collided held high across the return to PLAY
    step(0, 1, 1, 1);
    chk("draw.state", 8'(o_st[0]), 8'h02);
    repeat (HOLD + 3) step(0, 1, 1, 0);
    chk("held_col.state", 8'(o_st[0]), 8'h01);
    chk("held_col.p2", o_p2[0], 8'h01);
    chk("held_col.p1", o_p1[0], 8'h00);
    step(0, 0, 0, 0);

    // 4: player 1 reaches 3 on instance 0
    do_reset();
    step(1, 0, 0, 0);
    play_round(0, 1);
    play_round(0, 1);
    step(0, 1, 0, 1);
    chk("win.p1", o_p1[0], 8'h03);
    chk("win.state", 8'(o_st[0]), 8'h03);
    chk("win.game_over", 8'(o_go[0]), 8'h01);
    chk("win.winner", 8'(o_win[0]), 8'h01);
    chk("win.rr", 8'(o_rr[0]), 8'h00);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("restart.p1", o_p1[0], 8'h00);
    chk("restart.round", o_rnd[0], 8'h01);
    chk("restart.game_over", 8'(o_go[0]), 8'h00);
    chk("restart.rr", 8'(o_rr[0]), 8'h01);
    step(0, 0, 0, 0);
    chk("restart.rr_off", 8'(o_rr[0]), 8'h00);

    // 5: round counter through 09->10 and 99->00 (draws, instance 1)
    do_reset();
    step(1, 0, 0, 0);
    for (int r = 1; r <= 99; r++) begin
      play_round(1, 1);
      if (r == 8)  chk("round.09", o_rnd[1], 8'h09);
      if (r == 9)  chk("round.10", o_rnd[1], 8'h10);
      if (r == 98) chk("round.99", o_rnd[1], 8'h99);
      if (r == 99) chk("round.wrap", o_rnd[1], 8'h00);
    end

    // 6: reset two cycles into HOLD, then start+collide together in PLAY
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("prereset.state", 8'(o_st[0]), 8'h02);
    do_reset();
    chk("midhold.state", 8'(o_st[0]), 8'h00);
    chk("midhold.p2", o_p2[0], 8'h00);
    chk("midhold.freeze", 8'(o_freeze[0]), 8'h01);
    step(0, 1, 1, 0);
    chk("idle_col.state", 8'(o_st[0]), 8'h00);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 1);
    chk("both.p1", o_p1[0], 8'h01);
    chk("both.state", 8'(o_st[0]), 8'h02);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
